cache_fill_fsm: RTL
===================

# cache_fill_fsm

Cache miss handler. It sits between the cache arrays and the multi-cycle main memory, and acts as the read side of the memory interface. On a miss it issues one word read per cycle for the whole block, then writes each returned word into the cache data array at the correct word slot. When the last word arrives it commits the tag, and the cache arrays are never exposed to a partially filled block as valid.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, memory word width
- WORDS_PER_BLOCK, 8, words per cache block (power of two); block size = 2*WORDS_PER_BLOCK bytes

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- miss_detected  in  1  cache lookup missed this cycle
- miss_address  in  ADDR_W  byte address of the missing access
- memory_data  in  DATA_W  read data returning from memory
- memory_data_valid  in  1  memory_data valid this cycle
- fsm_busy  out  1  fill in progress; pipeline must stall
- mem_read_en  out  1  read request to memory this cycle
- memory_address  out  ADDR_W  word address of the current request
- write_data_array  out  1  write memory_data into data array this cycle
- word_offset  out  log2(WORDS_PER_BLOCK)  target word slot for write_data_array
- write_tag_array  out  1  write tag/valid for the block this cycle

## Operation
- States: IDLE and FILL. The state register and counters use the team's resettable enabled flop.
- IDLE → FILL occurs when miss_detected=1 at a rising edge.
  - On that same edge, the block base is latched: miss_address with its low log2(2*WORDS_PER_BLOCK) bits cleared.
  - issue_cnt and recv_cnt are cleared on that edge.
- In FILL, issue side:
  - mem_read_en=1 while issue_cnt < WORDS_PER_BLOCK.
  - memory_address = base + 2*issue_cnt.
  - issue_cnt increments by 1 each cycle until it saturates at WORDS_PER_BLOCK.
- In FILL, receive side, on each cycle with memory_data_valid=1:
  - write_data_array=1 and word_offset=recv_cnt, combinationally in that cycle.
  - recv_cnt increments.
- Completion: when memory_data_valid=1 and recv_cnt == WORDS_PER_BLOCK-1:
  - write_tag_array=1 in the same cycle as the final data write.
  - The next state is IDLE.
- fsm_busy=1 exactly while the state is FILL.
- Boundary conditions:
  - miss_detected while in FILL is ignored.
  - miss_address changes during FILL are ignored; the latched base is used.
  - memory_data_valid while in IDLE produces no writes.
  - Valid may arrive before all reads are issued, since issue and receive overlap.
  - Address arithmetic wraps modulo 2^ADDR_W. It never crosses a block boundary because base is aligned.
  - rst mid-fill forces IDLE on the next edge: counters are cleared and no tag write occurs. The partial block stays invalid.
- Reset values: state IDLE, counters 0, base 0.
  - All outputs 0: fsm_busy, mem_read_en, write_data_array, write_tag_array, memory_address, word_offset.

## Timing
- Cycle 0: miss_detected sampled. Cycle 1: FILL, fsm_busy=1, first request.
- Requests are issued in cycles 1..WORDS_PER_BLOCK, one per cycle with no gaps.
- Data returns at memory latency L after each request (L=4 for the team memory). The FSM does not assume L; it counts valid beats only.
- With L=4 and 8 words:
  - Writes occur in cycles 5..12.
  - write_tag_array is asserted in cycle 12.
  - Cycle 13 is IDLE with fsm_busy=0.
  - A new miss can be accepted at the edge ending cycle 13.
- Outputs are combinational from registered state and counters plus memory_data_valid. No registered output latency.

## Structure
- Shared package holds:
  - ADDR_W, DATA_W, WORDS_PER_BLOCK.
  - OFFSET_W = log2(WORDS_PER_BLOCK).
  - BLOCK_OFFSET_BITS = OFFSET_W+1.
  - State encoding IDLE=0, FILL=1.
- One natural sub-module, fill_counter: an (OFFSET_W+1)-bit counter with synchronous clear, enable and saturate. It is instantiated twice, for issue_cnt and recv_cnt.

## Test plan
- Reset then idle: hold rst 2 cycles with memory_data_valid toggling → all outputs 0, no writes.
- Basic fill, miss_address=0x1236, L=4:
  - Addresses 0x1230,0x1232..0x123E in cycles 1–8.
  - write_data_array cycles 5–12 with word_offset 0..7.
  - write_tag_array only in cycle 12; fsm_busy falls in cycle 13.
- Wrap/high block, miss_address=0xFFF1:
  - Addresses 0xFFF0..0xFFFE.
  - No overflow past 0xFFFE, 8 writes, 1 tag write.
- Miss during fill: second miss_detected with miss_address=0x4000 in cycle 3 → ignored; all addresses stay in the first block; exactly one tag write.
- Irregular latency: valid beats with gaps (cycles 5,7,8,11,12,14,15,16) → word_offset 0..7 in order; tag write in cycle 16 only.
- Reset mid-fill: rst in cycle 6 → IDLE in cycle 7, no tag write, later valid beats ignored; a fresh miss then completes normally.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared sizing, state encoding and address helpers for the cache miss handler.
// No timing of its own; constants only.
// No flow control.
package cache_fill_fsm_pkg;

    localparam int ADDR_W            = 16;
    localparam int DATA_W            = 16;
    localparam int WORDS_PER_BLOCK   = 8;
    localparam int OFFSET_W          = $clog2(WORDS_PER_BLOCK);
    localparam int BLOCK_OFFSET_BITS = OFFSET_W + 1;
    localparam int CNT_W             = OFFSET_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Clears the byte offset within a block so the base is block aligned.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] mask;
        mask = ~((ADDR_W'(1) << BLOCK_OFFSET_BITS) - ADDR_W'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Resettable beat counter with synchronous clear, enable and saturation at MAX.
// Count updates one cycle after enable.
// No flow control; holds at MAX until cleared.
module fill_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: streams one word read per cycle for a block, writes returned words, commits tag on last beat.
// Outputs are combinational from registered state/counters and memory_data_valid; first request one cycle after the miss.
// Never stalls the memory; counts valid beats only, and holds fsm_busy high until the block is complete.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_detected,
    input  logic [ADDR_W-1:0]   miss_address,
    input  logic [DATA_W-1:0]   memory_data,
    input  logic                memory_data_valid,
    output logic                fsm_busy,
    output logic                mem_read_en,
    output logic [ADDR_W-1:0]   memory_address,
    output logic                write_data_array,
    output logic [OFFSET_W-1:0] word_offset,
    output logic                write_tag_array
);

    fill_state_t       state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              start;
    logic              in_fill;
    logic              last_beat;

    // Read data goes straight to the data array; this block only steers it.
    logic unused_data;
    assign unused_data = ^memory_data;

    assign in_fill   = (state == FILL);
    assign start     = (state == IDLE) && miss_detected;
    assign last_beat = in_fill && memory_data_valid
                       && (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

    fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (in_fill),
        .cnt (issue_cnt)
    );

    fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_recv_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (in_fill && memory_data_valid),
        .cnt (recv_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state <= FILL;
                        base  <= block_base(miss_address);
                    end
                end
                FILL: begin
                    if (last_beat) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        fsm_busy         = in_fill;
        mem_read_en      = in_fill && (issue_cnt < CNT_W'(WORDS_PER_BLOCK));
        memory_address   = '0;
        write_data_array = in_fill && memory_data_valid;
        word_offset      = '0;
        write_tag_array  = last_beat;
        // Address is only driven while a request is live, so it never leaves the block.
        if (mem_read_en) begin
            memory_address = base + ADDR_W'({issue_cnt, 1'b0});
        end
        if (write_data_array) begin
            word_offset = recv_cnt[OFFSET_W-1:0];
        end
    end

endmodule
